mem_port_arbiter: RTL and testbench

//  Sits directly downstream of the pipelined LC-3b datapath.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port to one-port memory arbiter for the LC-3b pipeline; port B wins ties.
// Define ARB_JOINT_RESP_EN to serve simultaneous requests back to back with one joint response.
module mem_port_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read_a,
   input  logic [WIDTH-1:0] mem_address_a,
   output logic [WIDTH-1:0] mem_rdata_a,
   output logic             mem_resp_a,
   input  logic             mem_read_b,
   input  logic             mem_write_b,
   input  logic [1:0]       mem_wmask_b,
   input  logic [WIDTH-1:0] mem_address_b,
   input  logic [WIDTH-1:0] mem_wdata_b,
   output logic [WIDTH-1:0] mem_rdata_b,
   output logic             mem_resp_b,
   output logic             pmem_read,
   output logic             pmem_write,
   output logic [1:0]       pmem_wmask,
   output logic [WIDTH-1:0] pmem_address,
   output logic [WIDTH-1:0] pmem_wdata,
   input  logic [WIDTH-1:0] pmem_rdata,
   input  logic             pmem_resp
);

   typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_addr_q, a_addr_d;
   logic [WIDTH-1:0] b_addr_q, b_addr_d;
   logic [WIDTH-1:0] b_wdata_q, b_wdata_d;
   logic [1:0]       b_wmask_q, b_wmask_d;
   logic             b_write_q, b_write_d;
   logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
   logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
   logic             resp_a_q, resp_a_d;
   logic             resp_b_q, resp_b_d;
   logic             joint_q, joint_d;
   logic             elig_a, elig_b;

   // A port that is completing this cycle may still show its old request.
   assign elig_a = mem_read_a & ~resp_a_q;
   assign elig_b = (mem_read_b | mem_write_b) & ~resp_b_q;

   always_comb begin
      state_d   = state_q;
      a_addr_d  = a_addr_q;
      b_addr_d  = b_addr_q;
      b_wdata_d = b_wdata_q;
      b_wmask_d = b_wmask_q;
      b_write_d = b_write_q;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
      resp_a_d  = 1'b0;
      resp_b_d  = 1'b0;
      joint_d   = joint_q;
      unique case (state_q)
         IDLE: begin
            joint_d = 1'b0;
            if (elig_b) begin
               b_addr_d  = mem_address_b;
               b_wdata_d = mem_wdata_b;
               b_wmask_d = mem_wmask_b;
               b_write_d = mem_write_b;
               state_d   = SERVE_B;
`ifdef ARB_JOINT_RESP_EN
               if (elig_a) begin
                  a_addr_d = mem_address_a;
                  joint_d  = 1'b1;
               end
`endif
            end else if (elig_a) begin
               a_addr_d = mem_address_a;
               state_d  = SERVE_A;
            end
         end
         SERVE_A: begin
            if (pmem_resp) begin
               rdata_a_d = pmem_rdata;
               resp_a_d  = 1'b1;
               resp_b_d  = joint_q;
               joint_d   = 1'b0;
               state_d   = IDLE;
            end
         end
         SERVE_B: begin
            if (pmem_resp) begin
               if (!b_write_q) rdata_b_d = pmem_rdata;
               // A joint pair holds B's response until A completes.
               if (joint_q) begin
                  state_d = SERVE_A;
               end else begin
                  resp_b_d = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_addr_q  <= '0;
         b_addr_q  <= '0;
         b_wdata_q <= '0;
         b_wmask_q <= '0;
         b_write_q <= 1'b0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
         resp_a_q  <= 1'b0;
         resp_b_q  <= 1'b0;
         joint_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_addr_q  <= a_addr_d;
         b_addr_q  <= b_addr_d;
         b_wdata_q <= b_wdata_d;
         b_wmask_q <= b_wmask_d;
         b_write_q <= b_write_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
         resp_a_q  <= resp_a_d;
         resp_b_q  <= resp_b_d;
         joint_q   <= joint_d;
      end
   end

   assign mem_rdata_a = rdata_a_q;
   assign mem_rdata_b = rdata_b_q;
   assign mem_resp_a  = resp_a_q;
   assign mem_resp_b  = resp_b_q;

   assign pmem_read  = (state_q == SERVE_A) |
                       ((state_q == SERVE_B) & ~b_write_q);
   assign pmem_write = (state_q == SERVE_B) & b_write_q;

   always_comb begin
      pmem_address = '0;
      pmem_wdata   = '0;
      pmem_wmask   = 2'b00;
      if (state_q == SERVE_A) begin
         pmem_address = a_addr_q;
         pmem_wmask   = 2'b11;
      end else if (state_q == SERVE_B) begin
         pmem_address = b_addr_q;
         pmem_wdata   = b_wdata_q;
         pmem_wmask   = b_wmask_q;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; joint expectations follow ARB_JOINT_RESP_EN.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read_a;
   logic [15:0] mem_address_a;
   logic [15:0] mem_rdata_a;
   logic        mem_resp_a;
   logic        mem_read_b;
   logic        mem_write_b;
   logic [1:0]  mem_wmask_b;
   logic [15:0] mem_address_b;
   logic [15:0] mem_wdata_b;
   logic [15:0] mem_rdata_b;
   logic        mem_resp_b;
   logic        pmem_read;
   logic        pmem_write;
   logic [1:0]  pmem_wmask;
   logic [15:0] pmem_address;
   logic [15:0] pmem_wdata;
   logic [15:0] pmem_rdata;
   logic        pmem_resp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WIDTH(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_read_a    (mem_read_a),
      .mem_address_a (mem_address_a),
      .mem_rdata_a   (mem_rdata_a),
      .mem_resp_a    (mem_resp_a),
      .mem_read_b    (mem_read_b),
      .mem_write_b   (mem_write_b),
      .mem_wmask_b   (mem_wmask_b),
      .mem_address_b (mem_address_b),
      .mem_wdata_b   (mem_wdata_b),
      .mem_rdata_b   (mem_rdata_b),
      .mem_resp_b    (mem_resp_b),
      .pmem_read     (pmem_read),
      .pmem_write    (pmem_write),
      .pmem_wmask    (pmem_wmask),
      .pmem_address  (pmem_address),
      .pmem_wdata    (pmem_wdata),
      .pmem_rdata    (pmem_rdata),
      .pmem_resp     (pmem_resp)
   );

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      mem_read_a = 0; mem_address_a = 0;
      mem_read_b = 0; mem_write_b = 0; mem_wmask_b = 0;
      mem_address_b = 0; mem_wdata_b = 0;
      pmem_rdata = 0; pmem_resp = 0;

      // reset state
      step;
      chk("rst_read", 16'(pmem_read), 16'd0);
      chk("rst_write", 16'(pmem_write), 16'd0);
      chk("rst_addr", pmem_address, 16'h0000);
      chk("rst_wmask", 16'(pmem_wmask), 16'd0);
      chk("rst_resp_a", 16'(mem_resp_a), 16'd0);
      chk("rst_resp_b", 16'(mem_resp_b), 16'd0);
      chk("rst_rdata_a", mem_rdata_a, 16'h0000);
      rst_n = 1'b1;
      step;

      // A alone, pmem_resp two cycles after the request
      mem_read_a = 1; mem_address_a = 16'h0040;
      step;
      chk("a_read", 16'(pmem_read), 16'd1);
      chk("a_addr", pmem_address, 16'h0040);
      chk("a_wmask", 16'(pmem_wmask), 16'h0003);
      step;
      chk("a_hold", 16'(pmem_read), 16'd1);
      pmem_resp = 1; pmem_rdata = 16'hBEEF;
      step;
      pmem_resp = 0;
      chk("a_resp", 16'(mem_resp_a), 16'd1);
      chk("a_rdata", mem_rdata_a, 16'hBEEF);
      chk("a_idle", 16'(pmem_read), 16'd0);
      mem_read_a = 0;
      step;
      chk("a_pulse", 16'(mem_resp_a), 16'd0);
      chk("a_keep", mem_rdata_a, 16'hBEEF);

      // simultaneous A and B reads
      mem_read_a = 1; mem_address_a = 16'h0042;
      mem_read_b = 1; mem_address_b = 16'h1000;
      step;
      chk("pri_b_addr", pmem_address, 16'h1000);
      chk("pri_b_read", 16'(pmem_read), 16'd1);
      pmem_resp = 1; pmem_rdata = 16'h1234;
      step;
      pmem_resp = 0;
`ifdef ARB_JOINT_RESP_EN
      chk("jnt_no_b", 16'(mem_resp_b), 16'd0);
      chk("jnt_a_addr", pmem_address, 16'h0042);
      chk("jnt_a_read", 16'(pmem_read), 16'd1);
      pmem_resp = 1; pmem_rdata = 16'h5678;
      step;
      pmem_resp = 0;
      chk("jnt_resp_a", 16'(mem_resp_a), 16'd1);
      chk("jnt_resp_b", 16'(mem_resp_b), 16'd1);
      chk("jnt_rdata_a", mem_rdata_a, 16'h5678);
      chk("jnt_rdata_b", mem_rdata_b, 16'h1234);
      mem_read_a = 0; mem_read_b = 0;
`else
      chk("pri_resp_b", 16'(mem_resp_b), 16'd1);
      chk("pri_no_a", 16'(mem_resp_a), 16'd0);
      chk("pri_rdata_b", mem_rdata_b, 16'h1234);
      chk("pri_gap", 16'(pmem_read), 16'd0);
      mem_read_b = 0;
      step;
      chk("pri_a_addr", pmem_address, 16'h0042);
      chk("pri_a_read", 16'(pmem_read), 16'd1);
      chk("pri_b_pulse", 16'(mem_resp_b), 16'd0);
      pmem_resp = 1; pmem_rdata = 16'h5678;
      step;
      pmem_resp = 0;
      chk("pri_resp_a", 16'(mem_resp_a), 16'd1);
      chk("pri_rdata_a", mem_rdata_a, 16'h5678);
      chk("pri_b_quiet", 16'(mem_resp_b), 16'd0);
      mem_read_a = 0;
`endif
      step;

      // request held high through its response
      mem_read_a = 1; mem_address_a = 16'h0044;
      step;
      chk("g_read", 16'(pmem_read), 16'd1);
      pmem_resp = 1; pmem_rdata = 16'h1111;
      step;
      pmem_resp = 0;
      chk("g_resp", 16'(mem_resp_a), 16'd1);
      chk("g_idle", 16'(pmem_read), 16'd0);
      step;
      chk("g_no_regrant", 16'(pmem_read), 16'd0);
      chk("g_pulse", 16'(mem_resp_a), 16'd0);
      mem_read_a = 0;
      step;

      // B write with read also raised
      mem_write_b = 1; mem_read_b = 1; mem_address_b = 16'h2000;
      mem_wmask_b = 2'b01; mem_wdata_b = 16'h00AA;
      step;
      chk("w_write", 16'(pmem_write), 16'd1);
      chk("w_noread", 16'(pmem_read), 16'd0);
      chk("w_addr", pmem_address, 16'h2000);
      chk("w_wmask", 16'(pmem_wmask), 16'h0001);
      chk("w_wdata", pmem_wdata, 16'h00AA);
      pmem_resp = 1; pmem_rdata = 16'hDEAD;
      step;
      pmem_resp = 0;
      chk("w_resp", 16'(mem_resp_b), 16'd1);
      chk("w_rdata_keep", mem_rdata_b, 16'h1234);
      chk("w_done", 16'(pmem_write), 16'd0);
      mem_write_b = 0; mem_read_b = 0;
      step;

      // stray pmem_resp while idle
      pmem_resp = 1; pmem_rdata = 16'hFFFF;
      step;
      pmem_resp = 0;
      chk("s_resp_a", 16'(mem_resp_a), 16'd0);
      chk("s_resp_b", 16'(mem_resp_b), 16'd0);
      chk("s_rdata_a", mem_rdata_a, 16'h1111);
      chk("s_rdata_b", mem_rdata_b, 16'h1234);

      // reset in the middle of a B write
      mem_write_b = 1; mem_address_b = 16'h3000;
      mem_wmask_b = 2'b10; mem_wdata_b = 16'h5500;
      step;
      chk("r_write_on", 16'(pmem_write), 16'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("r_write_off", 16'(pmem_write), 16'd0);
      chk("r_addr", pmem_address, 16'h0000);
      chk("r_resp_b", 16'(mem_resp_b), 16'd0);
      chk("r_rdata_b", mem_rdata_b, 16'h0000);
      mem_write_b = 0;
      step;
      rst_n = 1'b1;
      step;
      chk("r_idle_w", 16'(pmem_write), 16'd0);
      chk("r_idle_r", 16'(pmem_read), 16'd0);

      // normal service after reset
      mem_read_a = 1; mem_address_a = 16'h0050;
      step;
      chk("r2_addr", pmem_address, 16'h0050);
      pmem_resp = 1; pmem_rdata = 16'h0A0A;
      step;
      pmem_resp = 0; mem_read_a = 0;
      chk("r2_rdata", mem_rdata_a, 16'h0A0A);
      step;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
